// File: rtl/ls_port_arbiter_pkg.sv
// Shared types and constants for the load/store d_cache port arbiter.
// Tag width, cache opcodes and the cache word-index field live here.
package ls_port_arbiter_pkg;

  localparam int TAG_W        = 5;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int DC_INDEX_LSB = 2;
  localparam int DC_INDEX_MSB = 6;

  typedef enum logic {
    LS_OP_LOAD  = 1'b0,
    LS_OP_STORE = 1'b1
  } ls_op_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } ls_load_entry_t;

  function automatic logic [DC_INDEX_MSB-DC_INDEX_LSB:0] dc_index(input logic [ADDR_W-1:0] addr);
    return addr[DC_INDEX_MSB:DC_INDEX_LSB];
  endfunction

endpackage

// File: rtl/ls_port_arbiter_if.sv
// Bundle of load, store, d_cache and CDB signals around the port arbiter.
// The slave modport is the arbiter's view; master is its surroundings.
interface ls_port_arbiter_if;
  import ls_port_arbiter_pkg::*;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [TAG_W-1:0]  ld_tag;
  logic              ld_ready;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ack;

  logic              dc_ls_ready;
  logic              dc_opcode;
  logic [ADDR_W-1:0] dc_address;
  logic [DATA_W-1:0] dc_data;
  logic [DATA_W-1:0] dc_data_out;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_grant;

  modport slave (
    input  ld_valid, ld_addr, ld_tag, st_valid, st_addr, st_data, dc_data_out, cdb_grant,
    output ld_ready, st_ack, dc_ls_ready, dc_opcode, dc_address, dc_data,
           cdb_valid, cdb_tag, cdb_data
  );

  modport master (
    output ld_valid, ld_addr, ld_tag, st_valid, st_addr, st_data, dc_data_out, cdb_grant,
    input  ld_ready, st_ack, dc_ls_ready, dc_opcode, dc_address, dc_data,
           cdb_valid, cdb_tag, cdb_data
  );

endinterface

// File: rtl/ls_port_arbiter_load_fifo.sv
// Circular FIFO of issued loads ({tag, addr}); head is visible combinationally.
// Push while full and pop while empty are ignored.
module ls_load_fifo
  import ls_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           nreset,
  input  logic           i_push,
  input  ls_load_entry_t i_push_data,
  input  logic           i_pop,
  output ls_load_entry_t o_head,
  output logic           o_full,
  output logic           o_empty
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

  ls_load_entry_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ls_port_arbiter.sv
// Shares the single d_cache port between queued loads and retiring stores,
// then holds each load result with its tag until the CDB accepts it.
module ls_port_arbiter
  import ls_port_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH         = 4,
  parameter int STORE_STREAK_MAX = 4
) (
  input  logic              clock,
  input  logic              nreset,
  ls_port_arbiter_if.slave  bus
);

  localparam int                  STREAK_W   = $clog2(STORE_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STORE_STREAK_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  ls_load_entry_t      w_head;
  ls_load_entry_t      w_push_data;
  logic                w_full;
  logic                w_empty;
  logic                w_ld_ready;
  logic                w_load_elig;
  logic                w_store_grant;
  logic                w_load_grant;

  logic                r_rd_pending;
  logic [TAG_W-1:0]    r_rd_tag;
  logic                r_res_valid;
  logic [TAG_W-1:0]    r_res_tag;
  logic [DATA_W-1:0]   r_res_data;
  logic [STREAK_W-1:0] r_streak;

  // nreset gates the combinational outputs so every output reads 0 while reset is held.
  assign w_ld_ready  = nreset && !w_full;
  assign w_push_data = '{tag: bus.ld_tag, addr: bus.ld_addr};

  ls_load_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clock       (clock),
    .nreset      (nreset),
    .i_push      (bus.ld_valid && w_ld_ready),
    .i_push_data (w_push_data),
    .i_pop       (w_load_grant),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign w_load_elig   = nreset && !w_empty && !r_rd_pending && (!r_res_valid || bus.cdb_grant);
  assign w_store_grant = nreset && bus.st_valid && !(w_load_elig && (r_streak == STREAK_CAP));
  assign w_load_grant  = !w_store_grant && w_load_elig;

  always_comb begin
    bus.dc_ls_ready = 1'b0;
    bus.dc_opcode   = LS_OP_LOAD;
    bus.dc_address  = '0;
    bus.dc_data     = '0;
    bus.st_ack      = 1'b0;
    if (w_store_grant) begin
      bus.dc_ls_ready = 1'b1;
      bus.dc_opcode   = LS_OP_STORE;
      bus.dc_address  = bus.st_addr;
      bus.dc_data     = bus.st_data;
      bus.st_ack      = 1'b1;
    end else if (w_load_grant) begin
      bus.dc_ls_ready = 1'b1;
      bus.dc_address  = w_head.addr;
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.cdb_valid = r_res_valid;
  assign bus.cdb_tag   = r_res_tag;
  assign bus.cdb_data  = r_res_data;

  // The streak only counts stores that actually pushed a waiting load aside.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_streak <= '0;
    end else if (!w_load_elig || w_load_grant) begin
      r_streak <= '0;
    end else if (w_store_grant && (r_streak != STREAK_CAP)) begin
      r_streak <= r_streak + STREAK_ONE;
    end
  end

  // A fresh return overrides a same-cycle CDB grant, replacing the held result.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_rd_pending <= 1'b0;
      r_rd_tag     <= '0;
      r_res_valid  <= 1'b0;
      r_res_tag    <= '0;
      r_res_data   <= '0;
    end else begin
      r_rd_pending <= w_load_grant;
      if (w_load_grant) begin
        r_rd_tag <= w_head.tag;
      end
      if (r_rd_pending) begin
        r_res_valid <= 1'b1;
        r_res_tag   <= r_rd_tag;
        r_res_data  <= bus.dc_data_out;
      end else if (bus.cdb_grant) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Bench for ls_port_arbiter: directed vector table, corner sequences and
// random traffic against a queue-based reference model with its own RAM.
module tb_ls_port_arbiter;
  import ls_port_arbiter_pkg::*;

  localparam int LQ_DEPTH   = 4;
  localparam int STREAK_MAX = 4;

  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  ls_port_arbiter_if bus();

  ls_port_arbiter #(
    .LQ_DEPTH         (LQ_DEPTH),
    .STORE_STREAK_MAX (STREAK_MAX)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  function automatic logic [31:0] initWord(input int i);
    if (i == 4) return 32'hCAFE_0001;
    if (i == 8) return 32'hBEEF_0008;
    return 32'hD00D_0000 + 32'(i);
  endfunction

  // Synchronous d_cache stand-in: writes on store, read data one cycle after a load.
  logic [31:0] ram [32];
  initial for (int i = 0; i < 32; i++) ram[i] = initWord(i);
  always @(posedge clock) begin
    if (bus.dc_ls_ready) begin
      if (bus.dc_opcode == 1'b1) ram[dc_index(bus.dc_address)] <= bus.dc_data;
      else                       bus.dc_data_out <= ram[dc_index(bus.dc_address)];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state: pending loads as a queue, one in-flight read, one held result.
  ls_load_entry_t mQ[$];
  bit          mPend, mRes, mLoadElig, eStoreWin, eLoadWin, eLdReady;
  logic [4:0]  mPendTag, mResTag;
  logic [31:0] mPendData, mResData, eAddr, eData;
  int          mStreak;
  logic [31:0] mMem [32];

  logic sLdReady, sStAck, sDc, sOp, sCdbV;
  logic [4:0] sCdbTag;

  typedef struct {
    bit ldV; logic [31:0] ldA; logic [4:0] ldT;
    bit stV; logic [31:0] stA; logic [31:0] stD; bit grant;
    bit eRdy; bit eDc; bit eOp; logic [31:0] eAddr; logic [31:0] eData; bit eAck;
    bit eCdbV; logic [4:0] eTag; logic [31:0] eCdbD;
  } tvec_t;
  tvec_t tv [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit lv, input logic [31:0] la, input logic [4:0] lt,
                               input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                               input bit cg);
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_tag    = lt;
    bus.st_valid  = sv;
    bus.st_addr   = sa;
    bus.st_data   = sd;
    bus.cdb_grant = cg;
  endtask

  task automatic modelReset();
    mQ.delete();
    mPend = 0; mRes = 0; mStreak = 0;
    mPendTag = '0; mPendData = '0; mResTag = '0; mResData = '0;
  endtask

  task automatic modelEval();
    mLoadElig = (mQ.size() > 0) && !mPend && (!mRes || bus.cdb_grant);
    eStoreWin = bus.st_valid && !(mLoadElig && mStreak == STREAK_MAX);
    eLoadWin  = !eStoreWin && mLoadElig;
    eLdReady  = mQ.size() < LQ_DEPTH;
    eAddr     = eStoreWin ? bus.st_addr : (eLoadWin ? mQ[0].addr : 32'h0);
    eData     = eStoreWin ? bus.st_data : 32'h0;
  endtask

  task automatic modelAdvance();
    ls_load_entry_t e;
    bit pushOk;
    pushOk = bus.ld_valid && eLdReady;
    e = '{tag: bus.ld_tag, addr: bus.ld_addr};
    if (mPend) begin
      mRes = 1; mResTag = mPendTag; mResData = mPendData;
    end else if (bus.cdb_grant) begin
      mRes = 0;
    end
    if (eLoadWin) begin
      ls_load_entry_t h;
      h = mQ.pop_front();
      mPend = 1; mPendTag = h.tag; mPendData = mMem[dc_index(h.addr)];
    end else begin
      mPend = 0;
    end
    if (eStoreWin) mMem[dc_index(bus.st_addr)] = bus.st_data;
    if (!mLoadElig || eLoadWin) mStreak = 0;
    else if (eStoreWin && mStreak < STREAK_MAX) mStreak++;
    if (pushOk) mQ.push_back(e);
  endtask

  task automatic sampleOutputs();
    sLdReady = bus.ld_ready; sStAck = bus.st_ack; sDc = bus.dc_ls_ready;
    sOp = bus.dc_opcode; sCdbV = bus.cdb_valid; sCdbTag = bus.cdb_tag;
  endtask

  task automatic finishCycle();
    @(posedge clock);
    modelAdvance();
    @(negedge clock);
  endtask

  task automatic stepModel(input string ph);
    #1;
    modelEval();
    sampleOutputs();
    checkOutput({ph, "_ld_ready"},   32'(bus.ld_ready),    32'(eLdReady));
    checkOutput({ph, "_st_ack"},     32'(bus.st_ack),      32'(eStoreWin));
    checkOutput({ph, "_dc_ls_ready"},32'(bus.dc_ls_ready), 32'(eStoreWin || eLoadWin));
    checkOutput({ph, "_dc_opcode"},  32'(bus.dc_opcode),   32'(eStoreWin));
    checkOutput({ph, "_dc_address"}, bus.dc_address,       eAddr);
    checkOutput({ph, "_dc_data"},    bus.dc_data,          eData);
    checkOutput({ph, "_cdb_valid"},  32'(bus.cdb_valid),   32'(mRes));
    if (mRes) begin
      checkOutput({ph, "_cdb_tag"},  32'(bus.cdb_tag),     32'(mResTag));
      checkOutput({ph, "_cdb_data"}, bus.cdb_data,         mResData);
    end
    finishCycle();
  endtask

  task automatic idleCycles(input int n, input bit cg, input string ph);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, cg);
      stepModel(ph);
    end
  endtask

  initial begin
    int acks;
    bit granted;
    logic [4:0] gotTags[$];

    for (int i = 0; i < 32; i++) mMem[i] = initWord(i);
    modelReset();

    // Reset with inputs active: every output must read 0.
    nreset = 1'b1;
    applyStimulus(1, 32'h40, 5'd1, 1, 32'h44, 32'h5555_5555, 1);
    #2 nreset = 1'b0;
    #1;
    checkOutput("reset_ld_ready",    32'(bus.ld_ready),    0);
    checkOutput("reset_st_ack",      32'(bus.st_ack),      0);
    checkOutput("reset_dc_ls_ready", 32'(bus.dc_ls_ready), 0);
    checkOutput("reset_dc_address",  bus.dc_address,       0);
    checkOutput("reset_dc_data",     bus.dc_data,          0);
    checkOutput("reset_cdb_valid",   32'(bus.cdb_valid),   0);
    checkOutput("reset_cdb_tag",     32'(bus.cdb_tag),     0);
    checkOutput("reset_cdb_data",    bus.cdb_data,         0);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    nreset = 1'b1;

    //            ldV ldA    ldT  stV stA    stD            g  rdy dc op addr   data          ack cV tag  cdbD
    tv[0]  = '{1, 32'h10, 5'd7, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 0, 5'd0, 32'h0};
    tv[1]  = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 1, 0, 32'h10, 32'h0,         0, 0, 5'd0, 32'h0};
    tv[2]  = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 0, 5'd0, 32'h0};
    tv[3]  = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 1, 5'd7, 32'hCAFE_0001};
    tv[4]  = '{0, 32'h0,  5'd0, 1, 32'h14, 32'h1234_5678, 1, 1, 1, 1, 32'h14, 32'h1234_5678, 1, 0, 5'd0, 32'h0};
    tv[5]  = '{1, 32'h14, 5'd3, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 0, 5'd0, 32'h0};
    tv[6]  = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 1, 0, 32'h14, 32'h0,         0, 0, 5'd0, 32'h0};
    tv[7]  = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 0, 5'd0, 32'h0};
    tv[8]  = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 1, 5'd3, 32'h1234_5678};
    tv[9]  = '{1, 32'h20, 5'd9, 1, 32'h24, 32'hA5A5_A5A5, 1, 1, 1, 1, 32'h24, 32'hA5A5_A5A5, 1, 0, 5'd0, 32'h0};
    tv[10] = '{0, 32'h0,  5'd0, 1, 32'h28, 32'h1111_1111, 1, 1, 1, 1, 32'h28, 32'h1111_1111, 1, 0, 5'd0, 32'h0};
    tv[11] = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 1, 0, 32'h20, 32'h0,         0, 0, 5'd0, 32'h0};
    tv[12] = '{0, 32'h0,  5'd0, 1, 32'h2C, 32'h2222_2222, 1, 1, 1, 1, 32'h2C, 32'h2222_2222, 1, 0, 5'd0, 32'h0};
    tv[13] = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 1, 5'd9, 32'hBEEF_0008};
    tv[14] = '{0, 32'h0,  5'd0, 0, 32'h0,  32'h0,         1, 1, 0, 0, 32'h0,  32'h0,         0, 0, 5'd0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      string r;
      r = $sformatf("row%0d", i);
      applyStimulus(tv[i].ldV, tv[i].ldA, tv[i].ldT, tv[i].stV, tv[i].stA, tv[i].stD, tv[i].grant);
      #1;
      modelEval();
      checkOutput({r, "_ld_ready"},    32'(bus.ld_ready),    32'(tv[i].eRdy));
      checkOutput({r, "_dc_ls_ready"}, 32'(bus.dc_ls_ready), 32'(tv[i].eDc));
      checkOutput({r, "_dc_opcode"},   32'(bus.dc_opcode),   32'(tv[i].eOp));
      checkOutput({r, "_dc_address"},  bus.dc_address,       tv[i].eAddr);
      checkOutput({r, "_dc_data"},     bus.dc_data,          tv[i].eData);
      checkOutput({r, "_st_ack"},      32'(bus.st_ack),      32'(tv[i].eAck));
      checkOutput({r, "_cdb_valid"},   32'(bus.cdb_valid),   32'(tv[i].eCdbV));
      if (tv[i].eCdbV) begin
        checkOutput({r, "_cdb_tag"},   32'(bus.cdb_tag),     32'(tv[i].eTag));
        checkOutput({r, "_cdb_data"},  bus.cdb_data,         tv[i].eCdbD);
      end
      finishCycle();
    end

    // Store streak: with stores always present, a waiting load wins after STREAK_MAX acks.
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1, 32'h30 + 32'(n * 4), 5'(20 + n), 1, 32'h50, 32'h0BAD_0000 + 32'(n), 1);
      stepModel("streak");
      acks = 0;
      granted = 0;
      for (int c = 0; c < 20 && !granted; c++) begin
        applyStimulus(0, 0, 0, 1, 32'h54 + 32'(c * 4), 32'h0C00_0000 + 32'(c), 1);
        stepModel("streak");
        if (sDc && sOp == 1'b0) granted = 1;
        else if (sStAck) acks++;
      end
      checkOutput("streak_load_granted", 32'(granted), 1);
      checkOutput("streak_acks_before_load", 32'(acks), STREAK_MAX);
      applyStimulus(0, 0, 0, 1, 32'h70, 32'h7777_0000, 1);
      stepModel("streak");
      checkOutput("streak_store_resumes", 32'(sStAck), 1);
      idleCycles(3, 1, "streak_idle");
    end

    // Held result blocks further issue until the CDB grants; issue happens in the grant cycle.
    applyStimulus(1, 32'h10, 5'd1, 0, 0, 0, 0); stepModel("hold");
    applyStimulus(1, 32'h20, 5'd2, 0, 0, 0, 0); stepModel("hold");
    applyStimulus(1, 32'h14, 5'd3, 0, 0, 0, 0); stepModel("hold");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      stepModel("hold");
      checkOutput("hold_cdb_tag_stable", 32'(sCdbTag), 1);
      checkOutput("hold_no_issue", 32'(sDc), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    stepModel("hold");
    checkOutput("hold_issue_on_grant", 32'(sDc), 1);
    idleCycles(8, 1, "hold_drain");

    // Fill to full with the CDB blocked, then drain and check tag order.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'(i * 4), 5'(10 + i), 0, 0, 0, 0);
      stepModel("full");
    end
    checkOutput("full_ld_ready_low", 32'(sLdReady), 0);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      stepModel("full_drain");
      if (sCdbV) gotTags.push_back(sCdbTag);
    end
    checkOutput("full_result_count", 32'(gotTags.size()), 5);
    for (int i = 0; i < gotTags.size() && i < 5; i++)
      checkOutput($sformatf("full_order_%0d", i), 32'(gotTags[i]), 32'(10 + i));

    // Reset while a read is in flight: nothing may reach the CDB afterwards.
    applyStimulus(1, 32'h10, 5'd17, 0, 0, 0, 1); stepModel("midreset");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);         stepModel("midreset");
    applyStimulus(1, 32'h18, 5'd18, 1, 32'h1C, 32'h1, 1);
    #2 nreset = 1'b0;
    #1;
    checkOutput("midreset_ld_ready",    32'(bus.ld_ready),    0);
    checkOutput("midreset_st_ack",      32'(bus.st_ack),      0);
    checkOutput("midreset_dc_ls_ready", 32'(bus.dc_ls_ready), 0);
    checkOutput("midreset_cdb_valid",   32'(bus.cdb_valid),   0);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    nreset = 1'b1;
    modelReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      stepModel("postreset");
      checkOutput("postreset_ld_ready", 32'(sLdReady), 1);
      checkOutput("postreset_no_cdb", 32'(sCdbV), 0);
    end
    idleCycles(1, 1, "postreset");

    // Random mixed traffic against the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 9) < 4, {25'b0, 5'($urandom_range(0, 31)), 2'b00},
                    5'($urandom), $urandom_range(0, 9) < 4,
                    {25'b0, 5'($urandom_range(0, 31)), 2'b00}, $urandom,
                    $urandom_range(0, 9) < 6);
      stepModel("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
